// File: rtl/uart_regs_pkg.sv
// UART peripheral register map, CON bit positions and the echo engine state set.
// Shared by the UART peripheral and the echo master.
package uart_regs_pkg;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int CON_TXPERM = 0;
  localparam int CON_RXPERM = 1;
  localparam int CON_TXEN   = 2;
  localparam int CON_RXRDY  = 3;
  localparam int CON_TXBUSY = 4;

  localparam logic [4:0] CON_INIT = 5'b00011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_GAP_RX,
    ST_POLL_RX,
    ST_READ_RX,
    ST_GAP_TX,
    ST_POLL_TX,
    ST_WRITE_TX
  } echo_state_e;

  function automatic logic [7:0] ascii_upcase(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/uart_poll_timer.sv
// Loadable down-counter; done pulses for one cycle when a loaded count has run out.
module uart_poll_timer #(
  parameter int W = 4
) (
  input  logic         cpu_clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      cnt_d   = load_val;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) armed_d = 1'b0;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign done = armed_q && (cnt_q == '0);

endmodule

// File: rtl/uart_echo_master.sv
// Bus initiator that echoes every byte received by the UART back to its transmitter.
//   state    | meaning
//   IDLE     | parked, bus quiet
//   INIT     | write CON with tx/rx-clear permits
//   GAP_RX   | pause between RX polls; enable=0 parks here
//   POLL_RX  | read CON, look for rx ready
//   READ_RX  | read RXD into the hold register
//   GAP_TX   | pause between TX polls
//   POLL_TX  | read CON, wait for transmitter idle or give up
//   WRITE_TX | write hold byte to TXD
module uart_echo_master
  import uart_regs_pkg::*;
#(
  parameter int POLL_GAP   = 4,
  parameter int TX_TIMEOUT = 65535,
  parameter int CNT_W      = 16
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             upcase,
  output logic             rd,
  output logic             wr,
  output logic [31:0]      addr,
  output logic [7:0]       wdata,
  input  logic [31:0]      rdata,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count,
  output logic [7:0]       last_byte,
  output logic             err
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TX_TIMEOUT);

  echo_state_e      state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [TO_W-1:0]  tout_q, tout_d, tout_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       last_q, last_d;
  logic             err_q, err_d;
  logic             tmr_load, tmr_done;
  logic             go_rx_gap, go_tx_gap;
  logic             unused_rdata;

  assign unused_rdata = ^{rdata[31:5], rdata[CON_RXPERM]};
  assign tout_inc     = tout_q + 1'b1;

  uart_poll_timer #(.W(GAP_W)) u_gap_timer (
    .cpu_clk  (cpu_clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (GAP_LOAD),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    tout_d    = tout_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    go_rx_gap = 1'b0;
    go_tx_gap = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    addr      = '0;
    wdata     = '0;

    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_INIT;
      ST_INIT: begin
        wr        = 1'b1;
        addr      = ADDR_CON;
        wdata     = {3'b000, CON_INIT};
        go_rx_gap = 1'b1;
      end
      ST_GAP_RX: begin
        if (!enable)       state_d = ST_IDLE;
        else if (tmr_done) state_d = ST_POLL_RX;
      end
      ST_POLL_RX: begin
        rd   = 1'b1;
        addr = ADDR_CON;
        if (rdata[CON_RXRDY]) state_d = ST_READ_RX;
        else                  go_rx_gap = 1'b1;
      end
      ST_READ_RX: begin
        rd        = 1'b1;
        addr      = ADDR_RXD;
        hold_d    = upcase ? ascii_upcase(rdata[7:0]) : rdata[7:0];
        tout_d    = '0;
        go_tx_gap = 1'b1;
      end
      ST_GAP_TX: if (tmr_done) state_d = ST_POLL_TX;
      ST_POLL_TX: begin
        rd   = 1'b1;
        addr = ADDR_CON;
        if (!rdata[CON_TXEN] && !rdata[CON_TXBUSY] && rdata[CON_TXPERM]) begin
          state_d = ST_WRITE_TX;
        end else begin
          tout_d = tout_inc;
          // Give up on this byte and go back to listening; err stays set.
          if (tout_inc == TO_LIMIT) begin
            err_d     = 1'b1;
            go_rx_gap = 1'b1;
          end else begin
            go_tx_gap = 1'b1;
          end
        end
      end
      ST_WRITE_TX: begin
        wr        = 1'b1;
        addr      = ADDR_TXD;
        wdata     = hold_q;
        cnt_d     = cnt_q + 1'b1;
        last_d    = hold_q;
        go_rx_gap = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero-length gap collapses into the decision the gap state would make.
    if (go_rx_gap) begin
      if (POLL_GAP == 0) begin
        state_d = enable ? ST_POLL_RX : ST_IDLE;
      end else begin
        state_d  = ST_GAP_RX;
        tmr_load = 1'b1;
      end
    end
    if (go_tx_gap) begin
      if (POLL_GAP == 0) begin
        state_d = ST_POLL_TX;
      end else begin
        state_d  = ST_GAP_TX;
        tmr_load = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      tout_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign byte_count = cnt_q;
  assign last_byte  = last_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_echo_master.sv
// Two echo masters, each with its own UART register model: dut0 has no poll gap,
// a short TX timeout and a 2-bit counter; dut1 has a 2-cycle poll gap.
module tb_uart_echo_master;
  import uart_regs_pkg::*;

  logic cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic        reset_s[2];
  logic        enable_s[2];
  logic        upcase_s[2];
  logic        rd_s[2];
  logic        wr_s[2];
  logic [31:0] addr_s[2];
  logic [7:0]  wdata_s[2];
  logic [31:0] rdata_s[2];
  logic        busy_s[2];
  logic [7:0]  lastb_s[2];
  logic        err_s[2];
  logic [1:0]  cnt0;
  logic [15:0] cnt1;

  // UART responder model, one per DUT
  logic       rx_rdy[2]    = '{1'b0, 1'b0};
  logic [7:0] rx_data[2]   = '{8'h00, 8'h00};
  logic       tx_armed[2]  = '{1'b0, 1'b0};
  int         tx_polls[2]  = '{0, 0};
  int         busy_left[2] = '{0, 0};
  int         tx_wr_cnt[2] = '{0, 0};
  int         con_gap[2]   = '{0, 0};
  int         last_con[2]  = '{0, 0};
  logic [7:0] last_tx[2]   = '{8'h00, 8'h00};
  logic [1:0] con_lo[2]    = '{2'b00, 2'b00};
  int         cyc          = 0;

  logic       txen_force[2];
  logic       push_req[2];
  logic [7:0] push_data[2];
  int         busy_cfg[2];

  int checks = 0;
  int errors = 0;

  uart_echo_master #(.POLL_GAP(0), .TX_TIMEOUT(3), .CNT_W(2)) u_dut0 (
    .cpu_clk(cpu_clk), .reset(reset_s[0]), .enable(enable_s[0]), .upcase(upcase_s[0]),
    .rd(rd_s[0]), .wr(wr_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
    .busy(busy_s[0]), .byte_count(cnt0), .last_byte(lastb_s[0]), .err(err_s[0])
  );

  uart_echo_master #(.POLL_GAP(2), .TX_TIMEOUT(65535), .CNT_W(16)) u_dut1 (
    .cpu_clk(cpu_clk), .reset(reset_s[1]), .enable(enable_s[1]), .upcase(upcase_s[1]),
    .rd(rd_s[1]), .wr(wr_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
    .busy(busy_s[1]), .byte_count(cnt1), .last_byte(lastb_s[1]), .err(err_s[1])
  );

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdata_s[i] = 32'h0;
      if (addr_s[i] == ADDR_CON)
        rdata_s[i] = {27'h0, busy_left[i] != 0, rx_rdy[i], txen_force[i], con_lo[i]};
      else if (addr_s[i] == ADDR_RXD)
        rdata_s[i] = {24'h0, rx_data[i]};
    end
  end

  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rd_s[i] && addr_s[i] == ADDR_RXD) begin
        rx_rdy[i]    <= 1'b0;
        tx_armed[i]  <= 1'b1;
        tx_polls[i]  <= 0;
        busy_left[i] <= busy_cfg[i];
      end
      if (push_req[i]) begin
        rx_rdy[i]  <= 1'b1;
        rx_data[i] <= push_data[i];
      end
      if (rd_s[i] && addr_s[i] == ADDR_CON) begin
        if (tx_armed[i]) tx_polls[i] <= tx_polls[i] + 1;
        if (busy_left[i] != 0) busy_left[i] <= busy_left[i] - 1;
        con_gap[i]  <= cyc - last_con[i];
        last_con[i] <= cyc;
      end
      if (wr_s[i] && addr_s[i] == ADDR_TXD) begin
        tx_wr_cnt[i] <= tx_wr_cnt[i] + 1;
        last_tx[i]   <= wdata_s[i];
        tx_armed[i]  <= 1'b0;
      end
      if (wr_s[i] && addr_s[i] == ADDR_CON) con_lo[i] <= wdata_s[i][1:0];
    end
  end

  typedef struct {
    logic        en;
    logic        up;
    logic        push;
    logic [7:0]  pd;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    int          cnt;
    logic [7:0]  last;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic en, input logic up, input logic push, input logic [7:0] pd,
                      input logic r, input logic w, input logic [31:0] a, input logic [7:0] wd,
                      input logic b, input int c, input logic [7:0] l);
    vec_t v;
    v = '{en, up, push, pd, r, w, a, wd, b, c, l};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d);
    @(negedge cpu_clk);
    push_req[i]  = 1'b1;
    push_data[i] = d;
    @(negedge cpu_clk);
    push_req[i]  = 1'b0;
  endtask

  localparam logic [31:0] C = ADDR_CON;
  localparam logic [31:0] R = ADDR_RXD;
  localparam logic [31:0] T = ADDR_TXD;
  localparam logic [31:0] Z = 32'h0;

  initial begin
    int got;
    int wb;
    for (int i = 0; i < 2; i++) begin
      reset_s[i] = 1'b1; enable_s[i] = 1'b0; upcase_s[i] = 1'b0;
      txen_force[i] = 1'b0; push_req[i] = 1'b0; push_data[i] = 8'h00; busy_cfg[i] = 0;
    end

    // dut0 cycle trace: echo, upcase boundaries, 2-bit counter wrap, disable
    addv(1,0,0,8'h00, 0,0,Z,8'h00, 0,0,8'h00);
    addv(1,0,1,8'h41, 0,1,C,8'h03, 1,0,8'h00);
    addv(1,0,0,8'h00, 1,0,C,8'h00, 1,0,8'h00);
    addv(1,0,0,8'h00, 1,0,R,8'h00, 1,0,8'h00);
    addv(1,0,0,8'h00, 1,0,C,8'h00, 1,0,8'h00);
    addv(1,0,0,8'h00, 0,1,T,8'h41, 1,0,8'h00);
    addv(1,1,1,8'h7A, 1,0,C,8'h00, 1,1,8'h41);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,1,8'h41);
    addv(1,1,0,8'h00, 1,0,R,8'h00, 1,1,8'h41);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,1,8'h41);
    addv(1,1,1,8'h5B, 0,1,T,8'h5A, 1,1,8'h41);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,2,8'h5A);
    addv(1,1,0,8'h00, 1,0,R,8'h00, 1,2,8'h5A);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,2,8'h5A);
    addv(1,1,1,8'h60, 0,1,T,8'h5B, 1,2,8'h5A);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,3,8'h5B);
    addv(1,1,0,8'h00, 1,0,R,8'h00, 1,3,8'h5B);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,3,8'h5B);
    addv(1,1,1,8'h61, 0,1,T,8'h60, 1,3,8'h5B);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,0,8'h60);
    addv(1,1,0,8'h00, 1,0,R,8'h00, 1,0,8'h60);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,0,8'h60);
    addv(1,1,1,8'h7B, 0,1,T,8'h41, 1,0,8'h60);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,1,8'h41);
    addv(1,1,0,8'h00, 1,0,R,8'h00, 1,1,8'h41);
    addv(1,1,0,8'h00, 1,0,C,8'h00, 1,1,8'h41);
    addv(1,1,0,8'h00, 0,1,T,8'h7B, 1,1,8'h41);
    addv(0,1,0,8'h00, 1,0,C,8'h00, 1,2,8'h7B);
    addv(0,0,0,8'h00, 0,0,Z,8'h00, 0,2,8'h7B);

    repeat (3) @(negedge cpu_clk);
    #1;
    chk("rst_bus0", 64'({rd_s[0], wr_s[0], addr_s[0], wdata_s[0]}), 64'h0);
    chk("rst_stat0", 64'({busy_s[0], err_s[0], cnt0, lastb_s[0]}), 64'h0);
    chk("rst_bus1", 64'({rd_s[1], wr_s[1], addr_s[1], wdata_s[1]}), 64'h0);
    chk("rst_stat1", 64'({busy_s[1], err_s[1], cnt1, lastb_s[1]}), 64'h0);
    @(negedge cpu_clk);
    reset_s[0] = 1'b0;
    reset_s[1] = 1'b0;

    foreach (vecs[k]) begin
      @(negedge cpu_clk);
      enable_s[0]  = vecs[k].en;
      upcase_s[0]  = vecs[k].up;
      push_req[0]  = vecs[k].push;
      push_data[0] = vecs[k].pd;
      chk($sformatf("vec%0d_bus", k), 64'({rd_s[0], wr_s[0], addr_s[0], wdata_s[0]}),
          64'({vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata}));
      chk($sformatf("vec%0d_stat", k), 64'({busy_s[0], 32'(cnt0), lastb_s[0]}),
          64'({vecs[k].busy, vecs[k].cnt, vecs[k].last}));
    end
    @(negedge cpu_clk);
    push_req[0] = 1'b0;
    upcase_s[0] = 1'b0;

    // dut0 timeout: CON[2] stuck high, err after the 3rd TX poll, byte dropped
    txen_force[0] = 1'b1;
    enable_s[0]   = 1'b1;
    wb = tx_wr_cnt[0];
    push_byte(0, 8'h55);
    got = 0;
    for (int n = 0; n < 60 && got == 0; n++) begin
      @(negedge cpu_clk);
      if (err_s[0]) got = 1;
    end
    chk("to_err_seen", 64'(got), 64'd1);
    chk("to_polls", 64'(tx_polls[0]), 64'd3);
    chk("to_no_write", 64'(tx_wr_cnt[0]), 64'(wb));
    chk("to_cnt", 64'(cnt0), 64'd2);
    txen_force[0] = 1'b0;
    push_byte(0, 8'h30);
    got = 0;
    for (int n = 0; n < 60 && got == 0; n++) begin
      @(negedge cpu_clk);
      if (tx_wr_cnt[0] != wb) got = 1;
    end
    chk("to_next_write_seen", 64'(got), 64'd1);
    chk("to_next_byte", 64'({last_tx[0], lastb_s[0]}), 64'h3030);
    chk("to_next_cnt", 64'(cnt0), 64'd3);
    chk("to_err_sticky", 64'(err_s[0]), 64'd1);

    // dut0 reset asserted while in POLL_TX
    txen_force[0] = 1'b1;
    push_byte(0, 8'h31);
    got = 0;
    for (int n = 0; n < 60 && got == 0; n++) begin
      @(negedge cpu_clk);
      if (tx_armed[0] && rd_s[0] && addr_s[0] == ADDR_CON) got = 1;
    end
    chk("rst_poll_tx_seen", 64'(got), 64'd1);
    reset_s[0] = 1'b1;
    #1;
    chk("midrst_bus", 64'({rd_s[0], wr_s[0], addr_s[0], wdata_s[0]}), 64'h0);
    chk("midrst_stat", 64'({busy_s[0], err_s[0], cnt0, lastb_s[0]}), 64'h0);
    enable_s[0] = 1'b0;
    @(negedge cpu_clk);
    reset_s[0]    = 1'b0;
    txen_force[0] = 1'b0;

    // dut1: poll spacing and 10 busy TX polls
    busy_cfg[1] = 10;
    enable_s[1] = 1'b1;
    repeat (20) @(negedge cpu_clk);
    chk("rx_poll_gap", 64'(con_gap[1]), 64'd3);
    push_byte(1, 8'h48);
    got = 0;
    for (int n = 0; n < 300 && got == 0; n++) begin
      @(negedge cpu_clk);
      if (tx_wr_cnt[1] == 1) got = 1;
    end
    chk("busy_write_seen", 64'(got), 64'd1);
    chk("busy_polls", 64'(tx_polls[1]), 64'd11);
    chk("tx_poll_gap", 64'(con_gap[1]), 64'd3);
    chk("busy_byte", 64'({last_tx[1], lastb_s[1]}), 64'h4848);
    chk("busy_cnt_err", 64'({cnt1, err_s[1]}), 64'({16'd1, 1'b0}));
    repeat (20) @(negedge cpu_clk);
    chk("busy_single_write", 64'(tx_wr_cnt[1]), 64'd1);

    // dut1: enable dropped in GAP_TX, byte still goes out, then IDLE
    busy_cfg[1] = 2;
    push_byte(1, 8'h49);
    got = 0;
    for (int n = 0; n < 100 && got == 0; n++) begin
      if (tx_armed[1] && !rd_s[1] && !wr_s[1]) got = 1;
      else @(negedge cpu_clk);
    end
    chk("gap_tx_seen", 64'(got), 64'd1);
    enable_s[1] = 1'b0;
    got = 0;
    for (int n = 0; n < 60 && got == 0; n++) begin
      @(negedge cpu_clk);
      if (tx_wr_cnt[1] == 2) got = 1;
    end
    chk("dis_write_seen", 64'(got), 64'd1);
    chk("dis_byte", 64'({last_tx[1], lastb_s[1], cnt1}), 64'({8'h49, 8'h49, 16'd2}));
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      @(negedge cpu_clk);
      if (!busy_s[1]) got = 1;
    end
    chk("dis_idle_seen", 64'(got), 64'd1);
    repeat (10) @(negedge cpu_clk);
    chk("dis_parked", 64'({busy_s[1], rd_s[1], wr_s[1]}), 64'h0);
    chk("dis_no_extra", 64'(tx_wr_cnt[1]), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_master.md
Name: uart_echo_master

Overview:
- Autonomous bus initiator that drives the memory-mapped UART peripheral's register port in place of the CPU.
- Polls the UART control register for a received byte, reads it, optionally upper-cases it, waits for the transmitter to go idle, then writes the byte back to the TX data register.
- Sits beside the CPU on the peripheral bus, muxed in when echo mode is enabled.
- Used for board bring-up and serial-link self-test.

Parameters:
- POLL_GAP, 4: idle cycles inserted between consecutive control-register polls (0 = back-to-back).
- TX_TIMEOUT, 65535: maximum number of TX-busy polls before the error flag is raised.
- CNT_W, 16: width of the echoed-byte counter.

Ports:
- cpu_clk  in  1  system/bus clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run the echo engine, 0 = finish the current byte then park.
- upcase  in  1  1 = map ASCII 0x61..0x7A to 0x41..0x5A before transmit; sampled when RXD is read.
- rd  out  1  bus read strobe.
- wr  out  1  bus write strobe.
- addr  out  32  bus address.
- wdata  out  8  bus write data.
- rdata  in  32  bus read data; combinational from the responder, valid in the same cycle rd is high.
- busy  out  1  1 whenever the FSM is not in IDLE.
- byte_count  out  CNT_W  number of bytes written to TXD since reset; wraps modulo 2^CNT_W.
- last_byte  out  8  last byte written to TXD.
- err  out  1  sticky TX-timeout flag; cleared only by reset.

Behaviour:
- Register map, shared with the UART peripheral:
  - TXD at 0x40000018.
  - RXD at 0x4000001C.
  - CON at 0x40000020.
- CON bit meanings:
  - [0] tx permit.
  - [1] rx-clear permit.
  - [2] tx enable/busy.
  - [3] rx ready.
  - [4] tx busy.
- Bus protocol:
  - A read is one cycle with rd=1 and addr valid; the master samples rdata at the posedge closing that cycle. Any read side effect (e.g. RXD read clearing CON[3]) occurs at that same edge.
  - A write is one cycle with wr=1, addr and wdata valid.
  - rd and wr are never high together. When both are low, addr=0 and wdata=0.
- Reset values: rd=0, wr=0, addr=0, wdata=0, busy=0, byte_count=0, last_byte=0, err=0, state=IDLE, gap counter=0, timeout counter=0.
- FSM states and transitions:
  - IDLE: goes to INIT when enable=1.
  - INIT: write CON=0x03 for one cycle, then go to GAP_RX.
  - GAP_RX: wait POLL_GAP cycles, then go to POLL_RX. If enable=0 here, go to IDLE instead.
  - POLL_RX: read CON. If rdata[3]=1 go to READ_RX; otherwise go to GAP_RX.
  - READ_RX: read RXD and latch rdata[7:0], transformed per upcase, into the hold register. Clear the timeout counter, then go to GAP_TX.
  - GAP_TX: wait POLL_GAP cycles, then go to POLL_TX.
  - POLL_TX: read CON.
    - If rdata[2]=0 and rdata[4]=0 and rdata[0]=1, go to WRITE_TX.
    - Otherwise increment the timeout counter and go to GAP_TX.
    - If the counter reaches TX_TIMEOUT: set err=1, drop the byte, go to GAP_RX.
  - WRITE_TX: write TXD with the hold byte. byte_count+1, last_byte=hold. Go to GAP_RX.
- Throughput: with POLL_GAP=0, minimum latency from CON[3] set to the TXD write is 4 cycles (POLL_RX, READ_RX, POLL_TX, WRITE_TX), assuming TX is idle.
- enable deassertion:
  - Only honoured in GAP_RX; a byte already read is always transmitted or timed out.
  - Re-enable restarts through INIT.
- upcase applies only to 0x61..0x7A; all other values pass unchanged.
- byte_count wraps from all-ones to 0 without a flag.
- err is sticky; the engine keeps running after an error.
- Reset asserted mid-operation returns all state to reset values immediately. A partially completed bus cycle is abandoned with rd/wr forced low asynchronously.
- Exactly one bus access per cycle; every access state lasts exactly one cycle.

Decomposition:
- Package uart_regs_pkg holds:
  - address constants ADDR_TXD, ADDR_RXD, ADDR_CON;
  - CON bit indices CON_TXPERM, CON_RXPERM, CON_TXEN, CON_RXRDY, CON_TXBUSY;
  - the CON init value 5'b00011;
  - the FSM state enum.
  The UART peripheral also adopts this package.
- One sub-module, uart_poll_timer: a loadable down-counter with a done pulse that implements POLL_GAP waits.

Test Plan:
- Basic echo: bench responder model; POLL_GAP=0, enable=1; responder sets CON[3] with RXD=0x41 -> INIT write CON=0x03; then read CON, read RXD, read CON, write 0x40000018 wdata=0x41; byte_count=1, last_byte=0x41.
- Upcase: upcase=1, RXD=0x7A -> TXD written 0x5A. RXD=0x5B -> TXD written 0x5B.
- TX busy: model holds CON[4]=1 for 10 polls after the RXD read -> no TXD write until CON[4]=0; then exactly one write; err=0.
- Timeout: TX_TIMEOUT=3, CON[2] held at 1 -> err=1 after the 3rd TX poll; no TXD write; FSM returns to polling RX; next byte 0x30 echoed normally.
- Disable and reset: enable dropped while in GAP_TX -> the byte is still transmitted, then IDLE with busy=0. Reset pulsed mid POLL_TX -> rd=0 and all outputs at reset values at once.
- Counter wrap: CNT_W=2, echo 5 bytes -> byte_count sequence 1,2,3,0,1.
